counter_sequencer: RTL
======================

Name: counter_sequencer

Overview:
Sequences NUM_CNT counter_fsm-style counters, each with a go/done/out interface, so that exactly one counter runs at a time in a fixed order. The block pulses each counter's go, waits for its done, then launches the next counter. It also muxes the active counter's output onto the LEDs, counts completed laps, and halts on a watchdog timeout. It sits in the top level between the clock divider and the counter instances, on the same (divided) clock as the counters.

Parameters:
NUM_CNT, 2, number of sequenced counters (2..8)
OUT_WIDTH, 4, width of each counter output and of led
IDX_WIDTH, 3, width of active_idx (must satisfy 2**IDX_WIDTH >= NUM_CNT)
TIMEOUT, 64, maximum cycles in RUN without done before halt (>= 2)
LAP_WIDTH, 8, width of lap counter

Ports:
clk  input  1  counter-domain clock
rst  input  1  asynchronous, active-high reset
start  input  1  level; begins sequencing from IDLE or HALT
stop  input  1  one-cycle pulse; finish current run, then go IDLE
done  input  NUM_CNT  per-counter done pulses
cnt_out  input  NUM_CNT*OUT_WIDTH  counter outputs; counter i occupies bits [i*OUT_WIDTH +: OUT_WIDTH]
go  output  NUM_CNT  one-hot, one-cycle launch pulses
led  output  OUT_WIDTH  registered copy of active counter output
active_idx  output  IDX_WIDTH  index of owning counter
busy  output  1  high in LAUNCH or RUN
timeout_err  output  1  sticky watchdog flag
laps  output  LAP_WIDTH  completed full sequences, saturating

Behaviour:
- Clocking and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, go=0, led=0, active_idx=0, busy=0, timeout_err=0, laps=0, stop_pending=0, watchdog=0.
- States: IDLE, LAUNCH, RUN, HALT.
- IDLE:
  - go=0.
  - start=1 moves to LAUNCH next cycle.
  - start and stop in the same cycle: stop wins, stay in IDLE.
- LAUNCH:
  - Lasts exactly 1 cycle. go[active_idx]=1, all other go bits 0.
  - watchdog cleared.
  - Next state RUN.
- RUN:
  - watchdog increments each cycle.
  - done[active_idx]=1 in cycle t:
    - active_idx advances at t+1.
    - If stop_pending=0: state=LAUNCH at t+1 and go for the next counter asserts at t+1 (1-cycle done-to-go latency).
    - If stop_pending=1: state=IDLE at t+1 and stop_pending clears.
  - done bits of non-active counters are ignored in every state.
  - watchdog reaching TIMEOUT-1 with no done: timeout_err=1, state=HALT next cycle; active_idx is unchanged.
- stop:
  - Pulse in LAUNCH or RUN sets stop_pending.
  - Pulse in IDLE or HALT has no effect.
- Index advance:
  - active_idx+1, wrapping from NUM_CNT-1 to 0.
  - On wrap, laps increments, saturating at all-ones.
- led: every cycle, led <= cnt_out slice selected by active_idx (1-cycle latency). It keeps updating in IDLE and HALT.
- HALT:
  - go=0, busy=0.
  - start=1 clears timeout_err and goes to LAUNCH with the same active_idx.
- start while busy is ignored.
- rst asserted mid-run returns all registers to their reset values immediately, with no go pulse.

Optional Feature:
Macro COUNTER_SEQUENCER_PINGPONG_EN.
- Defined: index order bounces 0,1,…,NUM_CNT-1,NUM_CNT-2,…,1,0,… using an internal direction bit (reset: ascending). laps increments each time the index returns to 0. With NUM_CNT=2 the order is identical to round-robin.
- Undefined: round-robin wrap as described under Behaviour; no direction bit is synthesized.

Test Plan:
- Setup: NUM_CNT=3, TIMEOUT=40; bench models counters that raise done 16 cycles after go.
- Reset, then start=1 → go=3'b001 one cycle after start; done[0] at t → go=3'b010 at t+1, active_idx=1.
- Run three counter completions → active_idx wraps 2→0, laps=1, go=3'b001 one cycle after done[2]; led tracks the active counter's cnt_out with 1-cycle lag.
- Stop pulse mid-run on counter 1 → no further go; state IDLE one cycle after done[1]; busy=0; active_idx=2; a later start launches go=3'b100.
- Counter model never raises done → timeout_err=1 and busy=0 after 40 RUN cycles; start=1 clears timeout_err and re-pulses go on the same index.
- Spurious done[2] while counter 0 is active → ignored, no state change. start+stop in the same cycle from IDLE → stays IDLE, go stays 0.
- With COUNTER_SEQUENCER_PINGPONG_EN defined → go order 001,010,100,010,001; laps=1 after the return to 0.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: runs NUM_CNT go/done counters one at a time in a fixed
// order, mirrors the active counter's output onto led, counts completed laps
// and halts when a counter fails to report done within TIMEOUT cycles.
// Optional: define COUNTER_SEQUENCER_PINGPONG_EN for a bouncing index order
// (0..NUM_CNT-1..0) instead of round-robin wrap.
module counter_sequencer #(
  parameter int NUM_CNT   = 2,
  parameter int OUT_WIDTH = 4,
  parameter int IDX_WIDTH = 3,
  parameter int TIMEOUT   = 64,
  parameter int LAP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NUM_CNT-1:0]           done,
  input  logic [NUM_CNT*OUT_WIDTH-1:0] cnt_out,
  output logic [NUM_CNT-1:0]           go,
  output logic [OUT_WIDTH-1:0]         led,
  output logic [IDX_WIDTH-1:0]         active_idx,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [LAP_WIDTH-1:0]         laps
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CNT - 1);
  localparam logic [WD_W-1:0]      WD_MAX   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_HALT
  } state_t;

  state_t                 state_q;
  logic [NUM_CNT-1:0]     go_q;
  logic [OUT_WIDTH-1:0]   led_q;
  logic [IDX_WIDTH-1:0]   active_idx_q;
  logic                   busy_q;
  logic                   timeout_err_q;
  logic [LAP_WIDTH-1:0]   laps_q;
  logic                   stop_pending_q;
  logic [WD_W-1:0]        wd_q;

  logic [NUM_CNT-1:0]     sel_oh;
  logic [NUM_CNT-1:0]     next_oh;
  logic [OUT_WIDTH-1:0]   led_d;
  logic [IDX_WIDTH-1:0]   idx_next_d;
  logic [LAP_WIDTH-1:0]   laps_d;
  logic                   done_act;
  logic                   stop_eff;

`ifdef COUNTER_SEQUENCER_PINGPONG_EN
  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  dir_t dir_q;
  dir_t dir_d;
`endif

  // Decode the active index: one-hot select and output mux for led.
  always_comb begin
    sel_oh = '0;
    led_d  = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (active_idx_q == IDX_WIDTH'(i)) begin
        sel_oh[i] = 1'b1;
        led_d     = cnt_out[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Next counter in the sequence and the lap count that goes with it.
  always_comb begin
`ifdef COUNTER_SEQUENCER_PINGPONG_EN
    // Direction flips on reaching either end, so index 0 is never left going down.
    if (dir_q == DIR_UP) begin
      idx_next_d = active_idx_q + 1'b1;
    end else begin
      idx_next_d = active_idx_q - 1'b1;
    end
    dir_d = dir_q;
    if (idx_next_d == LAST_IDX) begin
      dir_d = DIR_DOWN;
    end else if (idx_next_d == '0) begin
      dir_d = DIR_UP;
    end
`else
    idx_next_d = (active_idx_q == LAST_IDX) ? '0 : active_idx_q + 1'b1;
`endif
    next_oh = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (idx_next_d == IDX_WIDTH'(i)) begin
        next_oh[i] = 1'b1;
      end
    end
    laps_d = laps_q;
    if (idx_next_d == '0 && !(&laps_q)) begin
      laps_d = laps_q + 1'b1;
    end
    done_act = |(done & sel_oh);
    // A stop arriving together with done still ends the sequence after this run.
    stop_eff = stop_pending_q | stop;
  end

  // Sequencer FSM with registered go/busy/index/lap/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      go_q           <= '0;
      led_q          <= '0;
      active_idx_q   <= '0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      laps_q         <= '0;
      stop_pending_q <= 1'b0;
      wd_q           <= '0;
`ifdef COUNTER_SEQUENCER_PINGPONG_EN
      dir_q          <= DIR_UP;
`endif
    end else begin
      led_q <= led_d;
      go_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q <= S_LAUNCH;
            go_q    <= sel_oh;
            busy_q  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          wd_q    <= '0;
          state_q <= S_RUN;
          if (stop) begin
            stop_pending_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (done_act) begin
            active_idx_q <= idx_next_d;
            laps_q       <= laps_d;
`ifdef COUNTER_SEQUENCER_PINGPONG_EN
            dir_q        <= dir_d;
`endif
            if (stop_eff) begin
              state_q        <= S_IDLE;
              busy_q         <= 1'b0;
              stop_pending_q <= 1'b0;
            end else begin
              state_q <= S_LAUNCH;
              go_q    <= next_oh;
            end
          end else if (wd_q == WD_MAX) begin
            timeout_err_q  <= 1'b1;
            state_q        <= S_HALT;
            busy_q         <= 1'b0;
            stop_pending_q <= 1'b0;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (stop) begin
              stop_pending_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (start) begin
            timeout_err_q <= 1'b0;
            state_q       <= S_LAUNCH;
            go_q          <= sel_oh;
            busy_q        <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign go          = go_q;
  assign led         = led_q;
  assign active_idx  = active_idx_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign laps        = laps_q;

endmodule
